// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
// Serial-to-parallel UART receiver (8N1, LSB first) with 16x oversampling and
// start-bit glitch rejection. Accepted bytes go into a small circular FIFO and
// into a shift-register history of the last DEPTH bytes (newest in [7:0]).
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   rx         asynchronous serial line, idles high
//   rd_en      pop the oldest FIFO byte (ignored when empty)
//   clear_err  clear the sticky error flags (a coincident new error wins)
//   data_out   oldest FIFO byte, 0 when the FIFO is empty
//   empty      FIFO empty
//   full       FIFO full
//   count      number of FIFO entries
//   rx_done    one-cycle pulse when a byte is accepted
//   history    last DEPTH accepted bytes, newest in [7:0]
//   frame_err  sticky: stop bit was sampled low
//   overrun    sticky: a byte was dropped because the FIFO was full
//
// Handshake: rd_en is a single-cycle request sampled on the rising edge; a pop
// happens on that edge only when count != 0. There is no backpressure on the
// serial side: an accepted byte is pushed on the edge where rx_done rises.
// -----------------------------------------------------------------------------
module uart_rx_core #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600,
    parameter int DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rx,
    input  logic                       rd_en,
    input  logic                       clear_err,
    output logic [7:0]                 data_out,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       rx_done,
    output logic [DEPTH*8-1:0]         history,
    output logic                       frame_err,
    output logic                       overrun
);

    localparam int DIV = CLK_FREQ / (BAUD * 16);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;

    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic              rx_s1_q, rx_s1_d;
    logic              rx_s2_q, rx_s2_d;
    logic              rxs;

    logic [DW-1:0]     div_cnt_q, div_cnt_d;
    logic              tick;

    state_t            state_q, state_d;
    logic [3:0]        tc_q, tc_d;
    logic [2:0]        bi_q, bi_d;
    logic [7:0]        shift_q, shift_d;

    logic              accept_evt;
    logic              frame_evt;

    logic              rx_done_q, rx_done_d;
    logic [DEPTH*8-1:0] history_q, history_d;
    logic [7:0]        mem_q [DEPTH];
    logic [7:0]        mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;

    logic              fifo_empty;
    logic              fifo_full;
    logic              pop;
    logic              push;

    // ------------------------------------------------------------------
    // Input synchronizer and oversampling tick
    // ------------------------------------------------------------------
    assign rxs = rx_s2_q;

    // The divider is held at 0 while idle so the first tick after leaving
    // IDLE lands a full DIV clocks later; this keeps the mid-bit sample
    // points aligned to the start-bit edge.
    assign tick = (div_cnt_q == DIV_LAST);

    always_comb begin
        rx_s1_d   = rx;
        rx_s2_d   = rx_s1_q;
        div_cnt_d = div_cnt_q + DW'(1);
        if (state_q == IDLE || tick) begin
            div_cnt_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tc_q    <= '0;
            bi_q    <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            tc_q    <= tc_d;
            bi_q    <= bi_d;
            shift_q <= shift_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        tc_d    = tc_q;
        bi_d    = bi_q;
        shift_d = shift_q;
        unique case (state_q)
            IDLE: begin
                tc_d = '0;
                bi_d = '0;
                if (!rxs) begin
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    if (tc_q == 4'd7) begin
                        tc_d    = '0;
                        bi_d    = '0;
                        // A line that is high again at mid start bit was a glitch.
                        state_d = rxs ? IDLE : DATA;
                    end else begin
                        tc_d = tc_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    tc_d = tc_q + 4'd1;
                    if (tc_q == 4'd15) begin
                        shift_d[bi_q] = rxs;
                        bi_d          = bi_q + 3'd1;
                        if (bi_q == 3'd7) begin
                            state_d = STOP;
                        end
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    tc_d = tc_q + 4'd1;
                    if (tc_q == 4'd15) begin
                        state_d = rxs ? IDLE : WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                // Hold off until the line returns high so a break does not
                // look like a stream of start bits.
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode (stop-bit sample outcome)
    // ------------------------------------------------------------------
    always_comb begin
        accept_evt = 1'b0;
        frame_evt  = 1'b0;
        if (state_q == STOP && tick && tc_q == 4'd15) begin
            accept_evt = rxs;
            frame_evt  = !rxs;
        end
    end

    // ------------------------------------------------------------------
    // FIFO, history and flags
    // ------------------------------------------------------------------
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == COUNT_MAX);
    assign pop        = rd_en && !fifo_empty;
    // When full, a same-cycle pop frees the slot before the push lands.
    assign push       = accept_evt && (!fifo_full || pop);

    always_comb begin
        rx_done_d   = accept_evt;
        history_d   = history_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;

        if (accept_evt) begin
            history_d = {history_q[DEPTH*8-9:0], shift_q};
        end
        if (push) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (clear_err) begin
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end
        if (frame_evt) begin
            frame_err_d = 1'b1;
        end
        if (accept_evt && !push) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            div_cnt_q   <= '0;
            rx_done_q   <= 1'b0;
            history_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rx_s1_q     <= rx_s1_d;
            rx_s2_q     <= rx_s2_d;
            div_cnt_q   <= div_cnt_d;
            rx_done_q   <= rx_done_d;
            history_q   <= history_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign data_out  = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
    assign empty     = fifo_empty;
    assign full      = fifo_full;
    assign count     = count_q;
    assign rx_done   = rx_done_q;
    assign history   = history_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_core
// Directed bench for uart_rx_core with CLK_FREQ=1_600_000, BAUD=10_000
// (DIV=10, 160 clocks per bit). Inputs change 1 ns after a rising edge;
// outputs are checked on the falling edge.
// -----------------------------------------------------------------------------
module tb_uart_rx_core;

    localparam int DEPTH = 4;
    localparam int BIT   = 160;

    logic        clk;
    logic        rst_n;
    logic        rx;
    logic        rd_en;
    logic        clear_err;
    logic [7:0]  data_out;
    logic        empty;
    logic        full;
    logic [2:0]  count;
    logic        rx_done;
    logic [31:0] history;
    logic        frame_err;
    logic        overrun;

    int tests    = 0;
    int fails    = 0;
    int done_cnt = 0;
    int d0;

    uart_rx_core #(
        .CLK_FREQ (1_600_000),
        .BAUD     (10_000),
        .DEPTH    (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rd_en     (rd_en),
        .clear_err (clear_err),
        .data_out  (data_out),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .rx_done   (rx_done),
        .history   (history),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Count rx_done pulses, sampled away from the active edge
    always @(negedge clk) begin
        if (rx_done) done_cnt++;
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one frame: start, 8 data bits LSB first, stop bit held low for
    // stop_low bit periods and then high. Iteration n takes effect at the
    // n-th rising edge after the start bit begins; the stop sample lands on
    // edge 1522, so pop_at_done raises rd_en for exactly that edge.
    // rst_at >= 0 pulses rst_n low for 3 clocks at that iteration.
    task automatic send_frame(input logic [7:0] b, input int stop_low,
                              input bit pop_at_done, input int rst_at);
        int total;
        int k;
        total = (10 + stop_low) * BIT + 40;
        for (int n = 0; n < total; n++) begin
            k = n / BIT;
            if (k == 0)                 rx = 1'b0;
            else if (k <= 8)            rx = b[k-1];
            else if (k < 9 + stop_low)  rx = 1'b0;
            else                        rx = 1'b1;
            rd_en = pop_at_done && (n == 1522);
            if (n == rst_at)     rst_n = 1'b0;
            if (n == rst_at + 3) rst_n = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        rx    = 1'b1;
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        rst_n     = 1'b0;
        rx        = 1'b1;
        rd_en     = 1'b0;
        clear_err = 1'b0;
        repeat (5) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("reset data_out", data_out, 8'h00);
        check("reset empty", empty, 1'b1);
        check("reset full", full, 1'b0);
        check("reset count", count, 3'd0);
        check("reset rx_done", rx_done, 1'b0);
        check("reset history", history, 32'h0);
        check("reset frame_err", frame_err, 1'b0);
        check("reset overrun", overrun, 1'b0);

        // Single byte
        tick();
        d0 = done_cnt;
        send_frame(8'hA5, 0, 1'b0, -10);
        @(negedge clk);
        check("a5 done pulses", done_cnt - d0, 1);
        check("a5 data_out", data_out, 8'hA5);
        check("a5 count", count, 3'd1);
        check("a5 history", history[7:0], 8'hA5);
        tick();
        pop_one();
        @(negedge clk);
        check("a5 pop empty", empty, 1'b1);
        check("a5 pop data_out", data_out, 8'h00);

        // Fill and overrun
        tick();
        send_frame(8'h11, 0, 1'b0, -10);
        send_frame(8'h22, 0, 1'b0, -10);
        send_frame(8'h33, 0, 1'b0, -10);
        send_frame(8'h44, 0, 1'b0, -10);
        @(negedge clk);
        check("fill full", full, 1'b1);
        check("fill count", count, 3'd4);
        check("fill overrun", overrun, 1'b0);
        tick();
        d0 = done_cnt;
        send_frame(8'h55, 0, 1'b0, -10);
        @(negedge clk);
        check("ovr done pulses", done_cnt - d0, 1);
        check("ovr overrun", overrun, 1'b1);
        check("ovr count", count, 3'd4);
        check("ovr history", history, 32'h22334455);
        check("ovr pop0", data_out, 8'h11);
        tick();
        pop_one();
        @(negedge clk);
        check("ovr pop1", data_out, 8'h22);
        tick();
        pop_one();
        @(negedge clk);
        check("ovr pop2", data_out, 8'h33);
        tick();
        pop_one();
        @(negedge clk);
        check("ovr pop3", data_out, 8'h44);
        tick();
        pop_one();
        @(negedge clk);
        check("ovr drained", empty, 1'b1);
        tick();
        pulse_clear();
        @(negedge clk);
        check("ovr cleared", overrun, 1'b0);

        // Start-bit glitch
        tick();
        d0 = done_cnt;
        rx = 1'b0;
        repeat (40) tick();
        rx = 1'b1;
        repeat (300) tick();
        @(negedge clk);
        check("glitch no done", done_cnt - d0, 0);
        check("glitch frame_err", frame_err, 1'b0);
        check("glitch overrun", overrun, 1'b0);
        check("glitch count", count, 3'd0);

        // Framing error, then recovery
        tick();
        d0 = done_cnt;
        send_frame(8'h3C, 3, 1'b0, -10);
        @(negedge clk);
        check("ferr flag", frame_err, 1'b1);
        check("ferr count", count, 3'd0);
        check("ferr no done", done_cnt - d0, 0);
        tick();
        send_frame(8'h7E, 0, 1'b0, -10);
        @(negedge clk);
        check("ferr next data", data_out, 8'h7E);
        check("ferr next count", count, 3'd1);
        check("ferr still sticky", frame_err, 1'b1);
        tick();
        pulse_clear();
        @(negedge clk);
        check("ferr cleared", frame_err, 1'b0);
        tick();
        pop_one();

        // Full FIFO with pop on the accept edge
        send_frame(8'h01, 0, 1'b0, -10);
        send_frame(8'h02, 0, 1'b0, -10);
        send_frame(8'h03, 0, 1'b0, -10);
        send_frame(8'h04, 0, 1'b0, -10);
        d0 = done_cnt;
        send_frame(8'h05, 0, 1'b1, -10);
        @(negedge clk);
        check("pp done pulses", done_cnt - d0, 1);
        check("pp count", count, 3'd4);
        check("pp overrun", overrun, 1'b0);
        check("pp history", history, 32'h02030405);
        check("pp head", data_out, 8'h02);
        tick();
        pop_one();
        @(negedge clk);
        check("pp pop1", data_out, 8'h03);
        tick();
        pop_one();
        @(negedge clk);
        check("pp pop2", data_out, 8'h04);
        tick();
        pop_one();
        @(negedge clk);
        check("pp pop3", data_out, 8'h05);
        tick();
        pop_one();
        @(negedge clk);
        check("pp drained", count, 3'd0);

        // Reset in the middle of a frame
        tick();
        send_frame(8'h5A, 0, 1'b0, -10);
        d0 = done_cnt;
        send_frame(8'hFF, 0, 1'b0, 500);
        @(negedge clk);
        check("mrst no done", done_cnt - d0, 0);
        check("mrst data_out", data_out, 8'h00);
        check("mrst empty", empty, 1'b1);
        check("mrst full", full, 1'b0);
        check("mrst count", count, 3'd0);
        check("mrst history", history, 32'h0);
        check("mrst frame_err", frame_err, 1'b0);
        check("mrst overrun", overrun, 1'b0);
        tick();
        d0 = done_cnt;
        send_frame(8'h81, 0, 1'b0, -10);
        @(negedge clk);
        check("post rst done", done_cnt - d0, 1);
        check("post rst data", data_out, 8'h81);
        check("post rst count", count, 3'd1);
        check("post rst history", history, 32'h00000081);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
